// File: rtl/state_encoder_queue_if.sv
// Handshake bundle between fetch, the decode queue and the control unit.
// slave = queue side, master = producer/consumer environment side.
interface state_encoder_queue_if #(
    parameter int unsigned STATE_W = 7,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instruction;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        instr_out;
    logic [STATE_W-1:0] state_sel;
    logic               illegal;
    logic [CNT_W-1:0]   count;

    modport slave (
        input  flush, in_valid, instruction, out_ready,
        output in_ready, out_valid, instr_out, state_sel, illegal, count
    );

    modport master (
        output flush, in_valid, instruction, out_ready,
        input  in_ready, out_valid, instr_out, state_sel, illegal, count
    );
endinterface

// File: rtl/state_encoder_queue.sv
// FIFO of MIPS instructions decoded to FSM state codes at push time.
// Optional feature macro: STATE_ENC_ADD_EN (decode ADD to state 36).
module state_encoder_queue #(
    parameter int unsigned STATE_W = 7,
    parameter int unsigned DEPTH   = 4
) (
    input logic                  clk,
    input logic                  rst,
    state_encoder_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0] mem_instr [DEPTH];
    logic [5:0]  mem_code  [DEPTH];
    logic        mem_ill   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push, pop, empty;
    logic [5:0]       dec_code;
    logic             dec_bad;

    logic [5:0] op, fn;
    logic [4:0] rt;

    assign op = bus.instruction[31:26];
    assign fn = bus.instruction[5:0];
    assign rt = bus.instruction[20:16];

    always_comb begin
        dec_code = 6'd0;
        dec_bad  = 1'b0;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: dec_code = 6'd6;
                    6'b100011: dec_code = 6'd17;
                    6'b101011: dec_code = 6'd19;
                    6'b100100: dec_code = 6'd23;
                    6'b100101: dec_code = 6'd25;
                    6'b100110: dec_code = 6'd27;
                    6'b100111: dec_code = 6'd29;
                    6'b000000: dec_code = 6'd31;
                    6'b000011: dec_code = 6'd32;
                    6'b000010: dec_code = 6'd33;
                    6'b001011: dec_code = 6'd34;
                    6'b001010: dec_code = 6'd35;
`ifdef STATE_ENC_ADD_EN
                    6'b100000: dec_code = 6'd36;
`endif
                    default:   dec_bad  = 1'b1;
                endcase
            end
            6'b001001: dec_code = 6'd18;
            6'b001011: dec_code = 6'd20;
            6'b001100: dec_code = 6'd24;
            6'b001101: dec_code = 6'd26;
            6'b001110: dec_code = 6'd28;
            6'b001111: dec_code = 6'd30;
            6'b011100: begin
                case (fn)
                    6'b100001: dec_code = 6'd21;
                    6'b100000: dec_code = 6'd22;
                    default:   dec_bad  = 1'b1;
                endcase
            end
            6'b101000, 6'b101001, 6'b101011: dec_code = 6'd7;
            6'b000100: dec_code = 6'd11;
            6'b000001: begin
                if (rt == 5'b00001) dec_code = 6'd37;
                else                dec_bad  = 1'b1;
            end
            6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100: dec_code = 6'd13;
            default: dec_bad = 1'b1;
        endcase
    end

    // Ready/valid come only from registered occupancy, so a pop never frees a slot
    // for a same-cycle push and nothing on the input side reaches Out_* combinationally.
    assign empty         = (count_q == '0);
    assign bus.in_ready  = (count_q < FULL_CNT);
    assign bus.out_valid = !empty;
    assign bus.count     = count_q;
    assign push          = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop           = bus.out_ready && !empty && !bus.flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr_q] <= bus.instruction;
            mem_code[wr_ptr_q]  <= dec_code;
            mem_ill[wr_ptr_q]   <= dec_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is never cleared; gating by occupancy keeps stale entries invisible.
    assign bus.instr_out = empty ? 32'd0 : mem_instr[rd_ptr_q];
    assign bus.state_sel = empty ? '0 : STATE_W'(mem_code[rd_ptr_q]);
    assign bus.illegal   = empty ? 1'b0 : mem_ill[rd_ptr_q];
endmodule

// File: tb/tb_state_encoder_queue.sv
// Self-checking bench for state_encoder_queue: decode vector table plus
// hand-written full/wrap/flush/reset sequences, checked against a queue model.
module tb_state_encoder_queue;
    localparam int unsigned STATE_W = 7;
    localparam int unsigned DEPTH   = 4;

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  st;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [6:0]  st;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   m_count = 0;
    exp_t sb[$];
    vec_t vecs[18];

    always #5 clk = ~clk;

    state_encoder_queue_if #(.STATE_W(STATE_W), .DEPTH(DEPTH)) bus ();

    state_encoder_queue #(.STATE_W(STATE_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check pre-edge outputs against the model, step the model.
    task automatic cyc(input logic iv, input logic [31:0] ins, input logic [6:0] es,
                       input logic ei, input logic ordy, input logic fl);
        exp_t e;
        bit   push_ok, pop_ok;
        bus.in_valid    = iv;
        bus.instruction = ins;
        bus.out_ready   = ordy;
        bus.flush       = fl;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(m_count < DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(m_count != 0));
        chk("count", 32'(bus.count), 32'(m_count));
        if (m_count == 0) begin
            chk("empty_instr", bus.instr_out, 32'd0);
            chk("empty_state", 32'(bus.state_sel), 32'd0);
            chk("empty_illegal", 32'(bus.illegal), 32'd0);
        end
        push_ok = iv && (m_count < DEPTH);
        pop_ok  = ordy && (m_count != 0);
        if (fl) begin
            sb.delete();
            m_count = 0;
        end else begin
            if (pop_ok) begin
                e = sb.pop_front();
                chk("instr_out", bus.instr_out, e.instr);
                chk("state_sel", 32'(bus.state_sel), 32'(e.st));
                chk("illegal", 32'(bus.illegal), 32'(e.ill));
                m_count--;
            end
            if (push_ok) begin
                e.instr = ins;
                e.st    = es;
                e.ill   = ei;
                sb.push_back(e);
                m_count++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input int i, input logic ordy);
        cyc(1'b1, vecs[i].instr, vecs[i].st, vecs[i].ill, ordy, 1'b0);
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 32'd0, 7'd0, 1'b0, ordy, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && m_count != 0; k++) idle(1'b1);
        chk("drained", 32'(m_count), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"ADDU",  32'h00851821, 7'd6,  1'b0};
        vecs[1]  = '{"LW",    32'h8C880004, 7'd13, 1'b0};
        vecs[2]  = '{"SW",    32'hAC880004, 7'd7,  1'b0};
        vecs[3]  = '{"BEQ",   32'h10850003, 7'd11, 1'b0};
        vecs[4]  = '{"BGEZ",  32'h04A10002, 7'd37, 1'b0};
        vecs[5]  = '{"BAD",   32'hFC000000, 7'd0,  1'b1};
`ifdef STATE_ENC_ADD_EN
        vecs[6]  = '{"ADD",   32'h00851820, 7'd36, 1'b0};
`else
        vecs[6]  = '{"ADD",   32'h00851820, 7'd0,  1'b1};
`endif
        vecs[7]  = '{"SLL0",  32'h00000000, 7'd31, 1'b0};
        vecs[8]  = '{"SUBU",  32'h00851823, 7'd17, 1'b0};
        vecs[9]  = '{"ORI",   32'h34A50001, 7'd26, 1'b0};
        vecs[10] = '{"CLZ",   32'h70A01020, 7'd22, 1'b0};
        vecs[11] = '{"BLTZ",  32'h04A00002, 7'd0,  1'b1};
        vecs[12] = '{"SRL",   32'h00051042, 7'd33, 1'b0};
        vecs[13] = '{"LB",    32'h80880004, 7'd13, 1'b0};
        vecs[14] = '{"LUI",   32'h3C051234, 7'd30, 1'b0};
        vecs[15] = '{"ADDIU", 32'h24A50001, 7'd18, 1'b0};
        vecs[16] = '{"SLTIU", 32'h2CA50001, 7'd20, 1'b0};
        vecs[17] = '{"CLO",   32'h70A01021, 7'd21, 1'b0};

        bus.in_valid    = 1'b0;
        bus.instruction = 32'd0;
        bus.out_ready   = 1'b0;
        bus.flush       = 1'b0;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_state_sel", 32'(bus.state_sel), 32'd0);

        // ADDU push, pop next cycle
        push_vec(0, 1'b0);
        idle(1'b1);

        // Decode table, streamed with simultaneous push and pop
        foreach (vecs[i]) push_vec(i, 1'b1);
        drain();

        // Fill without popping, then 5th push against a same-cycle pop
        for (int i = 1; i <= 4; i++) push_vec(i, 1'b0);
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        push_vec(0, 1'b1);
        chk("fifth_dropped_count", 32'(bus.count), 32'd3);
        drain();

        // Pointer wrap over three fill/drain loops
        for (int loop = 0; loop < 3; loop++) begin
            for (int j = 0; j < DEPTH; j++) push_vec((loop * 5 + j) % 18, 1'b0);
            drain();
        end

        // Flush beats push and pop
        push_vec(8, 1'b0);
        push_vec(9, 1'b0);
        chk("pre_flush_count", 32'(bus.count), 32'd2);
        cyc(1'b1, vecs[10].instr, vecs[10].st, vecs[10].ill, 1'b1, 1'b1);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        push_vec(12, 1'b0);
        idle(1'b1);

        // Asynchronous reset between edges
        push_vec(13, 1'b0);
        push_vec(14, 1'b0);
        push_vec(15, 1'b0);
        bus.in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_count", 32'(bus.count), 32'd0);
        chk("async_rst_instr", bus.instr_out, 32'd0);
        sb.delete();
        m_count = 0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_vec(16, 1'b0);
        idle(1'b1);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
